// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, default base
// address and controller state encoding.
package irq_pkg;

  localparam logic [31:0] DefaultBaseAddr = 32'h7000_1000;

  localparam logic [3:0] OffPending  = 4'h0;
  localparam logic [3:0] OffEnable   = 4'h4;
  localparam logic [3:0] OffClaim    = 4'h8;
  localparam logic [3:0] OffComplete = 4'hC;

  // Claim IDs are 1..31, with 0 meaning "nothing".
  localparam int unsigned IdW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; id_o is the index of the lowest set bit plus one.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] vec_i,
  output logic             valid_o,
  output logic [IdW-1:0]   id_o
);

  always_comb begin
    valid_o = |vec_i;
    id_o    = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        id_o = IdW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: level-sensitive pending bits, enable mask,
// claim/complete handshake and a single registered interrupt line to the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned NUM_SRC   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [31:0]        rdata_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [IdW-1:0]     in_service_q, in_service_d;
  irq_state_e         state_q, state_d;
  logic               irq_q, irq_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] svc_mask;
  logic [NUM_SRC-1:0] claim_mask;
  logic               enc_valid;
  logic [IdW-1:0]     enc_id;
  logic               hit;
  logic               rd_acc;
  logic               wr_acc;
  logic               claim;
  logic               complete;

  assign active = pending_q & enable_q;

  irq_prio_enc #(
    .Width (NUM_SRC)
  ) u_prio_enc (
    .vec_i   (active),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  // Only the four word offsets of the window decode; everything else is ignored.
  assign hit      = (addr_i & ~32'hC) == BASE_ADDR;
  assign rd_acc   = en_i && !we_i && hit;
  assign wr_acc   = en_i && we_i && hit;
  assign claim    = rd_acc && (addr_i[3:0] == OffClaim) && (state_q == StReq) && enc_valid;
  assign complete = wr_acc && (addr_i[3:0] == OffComplete) && (state_q == StService) &&
                    (wdata_i == 32'(in_service_q));

  // A completing source is released in the same cycle so a held level re-pends next cycle.
  always_comb begin
    svc_mask   = '0;
    claim_mask = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      svc_mask[i]   = (state_q == StService) && !complete && (in_service_q == IdW'(i + 1));
      claim_mask[i] = claim && (enc_id == IdW'(i + 1));
    end
  end

  always_comb begin
    enable_d     = enable_q;
    pending_d    = (pending_q & ~claim_mask) | (src_i & ~(svc_mask | claim_mask));
    in_service_d = in_service_q;
    state_d      = state_q;

    if (wr_acc && (addr_i[3:0] == OffEnable)) begin
      enable_d = wdata_i[NUM_SRC-1:0];
    end

    unique case (state_q)
      StIdle: begin
        if (|active) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (claim) begin
          state_d      = StService;
          in_service_d = enc_id;
        end else if (~|(pending_q & enable_d)) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (complete) begin
          state_d      = StIdle;
          in_service_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    irq_d = (state_d == StReq);

    rdata_d = '0;
    if (rd_acc) begin
      case (addr_i[3:0])
        OffPending: rdata_d = 32'(pending_q);
        OffEnable:  rdata_d = 32'(enable_q);
        OffClaim:   rdata_d = claim ? 32'(enc_id) : '0;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q    <= '0;
      enable_q     <= '0;
      in_service_q <= '0;
      state_q      <= StIdle;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      in_service_q <= in_service_d;
      state_q      <= state_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
    end
  end

  assign irq_o   = irq_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized bus and
// source traffic checked every cycle against a behavioural model.
module tb_irq_controller;

  localparam logic [31:0] Base = 32'h7000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [7:0]  src;
  logic [31:0] rdata;
  logic        irq;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_pend;
  logic [7:0] m_en;
  int         m_svc;   // in-service ID, 0 when nothing is being serviced
  bit         m_req;   // interrupt currently being requested from the CPU

  logic [7:0]  src_hold;
  logic [31:0] v;

  irq_controller #(
    .BASE_ADDR (Base),
    .NUM_SRC   (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .src_i   (src),
    .rdata_o (rdata),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_id(input logic [7:0] vec);
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) return i + 1;
    end
    return 0;
  endfunction

  // One clock cycle: drive inputs, predict, clock, compare, then advance the model.
  task automatic step(input logic r, input logic e, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [7:0] s, output logic [31:0] got);
    logic [31:0] exp_rd;
    logic [7:0]  n_pend, n_en, blocked, act;
    int          n_svc, id;
    bit          n_req, hit, rd_a, wr_a, clm, cmp;
    logic [3:0]  off;
    rst = r; en = e; we = w; addr = a; wdata = d; src = s;
    exp_rd = '0;
    if (r) begin
      n_pend = '0; n_en = '0; n_svc = 0; n_req = 0;
    end else begin
      hit  = (a & ~32'hC) == Base;
      off  = a[3:0];
      rd_a = e && !w && hit;
      wr_a = e && w && hit;
      act  = m_pend & m_en;
      id   = lowest_id(act);
      clm  = rd_a && off == 4'h8 && m_req;
      cmp  = wr_a && off == 4'hC && m_svc != 0 && d == 32'(m_svc);
      if (rd_a) begin
        if (off == 4'h0) exp_rd = 32'(m_pend);
        else if (off == 4'h4) exp_rd = 32'(m_en);
        else if (off == 4'h8) exp_rd = clm ? 32'(id) : 32'd0;
      end
      n_en = (wr_a && off == 4'h4) ? d[7:0] : m_en;
      blocked = '0;
      if (m_svc != 0 && !cmp) blocked[m_svc-1] = 1'b1;
      if (clm) blocked[id-1] = 1'b1;
      n_pend = m_pend;
      if (clm) n_pend[id-1] = 1'b0;
      n_pend = n_pend | (s & ~blocked);
      n_svc = clm ? id : (cmp ? 0 : m_svc);
      if (m_req) n_req = !clm && ((m_pend & n_en) != 0);
      else if (m_svc != 0) n_req = 0;
      else n_req = (act != 0);
    end
    @(posedge clk);
    #1;
    got = rdata;
    check_eq("rdata", rdata, exp_rd);
    check_eq("irq", {31'b0, irq}, {31'b0, n_req});
    m_pend = n_pend; m_en = n_en; m_svc = n_svc; m_req = n_req;
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] got);
    step(1'b0, 1'b1, 1'b0, Base + 32'(off), 32'd0, src_hold, got);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    step(1'b0, 1'b1, 1'b1, Base + 32'(off), d, src_hold, dummy);
  endtask

  task automatic idle(input int n);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, src_hold, dummy);
  endtask

  task automatic do_reset();
    logic [31:0] dummy;
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, src_hold, dummy);
  endtask

  initial begin
    logic [31:0] a, d, got;
    int          k;
    m_pend = '0; m_en = '0; m_svc = 0; m_req = 0;
    src_hold = '0;

    // Reset state
    do_reset();
    do_reset();
    check_eq("rst_irq", {31'b0, irq}, 32'd0);
    rd(4'h0, v); check_eq("rst_pending", v, 32'd0);
    rd(4'h4, v); check_eq("rst_enable", v, 32'd0);
    rd(4'h8, v); check_eq("rst_claim", v, 32'd0);

    // Single source
    wr(4'h4, 32'h1);
    src_hold = 8'h01; idle(1);
    src_hold = 8'h00;
    check_eq("single_irq_early", {31'b0, irq}, 32'd0);
    idle(1);
    check_eq("single_irq", {31'b0, irq}, 32'd1);
    rd(4'h8, v); check_eq("single_claim", v, 32'd1);
    check_eq("single_irq_off", {31'b0, irq}, 32'd0);
    wr(4'hC, 32'd1);
    rd(4'h8, v); check_eq("single_idle_claim", v, 32'd0);

    // Priority and level re-pend
    do_reset();
    wr(4'h4, 32'hFF);
    src_hold = 8'h0A; idle(2);
    rd(4'h8, v); check_eq("prio_claim1", v, 32'd2);
    wr(4'hC, 32'd2); idle(1);
    rd(4'h8, v); check_eq("prio_claim2", v, 32'd2);
    src_hold = 8'h08;
    wr(4'hC, 32'd2); idle(1);
    rd(4'h8, v); check_eq("prio_claim3", v, 32'd4);
    rd(4'hC, v); check_eq("complete_read", v, 32'd0);
    step(1'b0, 1'b1, 1'b0, Base + 32'h10, 32'd0, src_hold, v);
    check_eq("unmapped_read", v, 32'd0);

    // Pending while disabled
    src_hold = 8'h00; do_reset();
    src_hold = 8'h80; idle(1);
    src_hold = 8'h00; idle(1);
    wr(4'h0, 32'h0);
    rd(4'h0, v); check_eq("dis_pending", v, 32'h80);
    check_eq("dis_irq", {31'b0, irq}, 32'd0);
    wr(4'h4, 32'hFFFF_FF80);
    rd(4'h4, v); check_eq("enable_upper", v, 32'h80);
    check_eq("dis_irq_on", {31'b0, irq}, 32'd1);

    // Wrong completion
    do_reset();
    wr(4'h4, 32'hFF);
    src_hold = 8'h04; idle(1);
    src_hold = 8'h00; idle(1);
    rd(4'h8, v); check_eq("wrong_claim", v, 32'd3);
    wr(4'hC, 32'd5);
    rd(4'h8, v); check_eq("wrong_claim_svc", v, 32'd0);
    wr(4'hC, 32'd3); idle(1);
    check_eq("wrong_irq", {31'b0, irq}, 32'd0);
    rd(4'h0, v); check_eq("wrong_pending", v, 32'd0);

    // Reset in service
    do_reset();
    wr(4'h4, 32'h1);
    src_hold = 8'h01; idle(2);
    rd(4'h8, v); check_eq("rsvc_claim", v, 32'd1);
    do_reset();
    check_eq("rsvc_irq", {31'b0, irq}, 32'd0);
    rd(4'h4, v); check_eq("rsvc_enable", v, 32'd0);
    wr(4'h4, 32'h1); idle(1);
    check_eq("rsvc_irq_on", {31'b0, irq}, 32'd1);

    // Randomized traffic against the model
    src_hold = 8'h00; do_reset();
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0, 1, 2, 3: a = Base + 32'(4 * k);
        4: a = Base + 32'h10;
        5: a = Base + 32'h2;
        6: a = Base - 32'h4;
        default: a = Base + 32'h8;
      endcase
      d = (k == 1) ? $urandom : 32'($urandom_range(0, 9));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           a, d, 8'($urandom & $urandom), got);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
